udma_cfg_master: RTL and testbench

APB-slave to uDMA configuration-bus initiator. It turns each APB transfer into exactly one handshake on one peripheral's cfg port (cfg_valid/cfg_rwn/cfg_addr/cfg_data out, cfg_data/cfg_ready back). Targets include the uDMA control block and the per-peripheral channel register files. It sits between the SoC APB interconnect and the uDMA top, and provides address decode, wait-state insertion and a bus-error timeout.

---
 rtl/udma_cfg_pkg.sv | 14 +
 rtl/udma_cfg_master.sv | 174 +++++++++++++++++
 tb/tb_udma_cfg_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/udma_cfg_pkg.sv
// Shared types and field positions for the uDMA configuration-bus master.
package udma_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int CFG_ADDR_WIDTH = 5;
  localparam int PERIPH_ID_LSB  = 7;
  localparam int CFG_REG_LSB    = 2;

endpackage

// File: rtl/udma_cfg_master.sv
// APB slave that turns each APB transfer into one cfg-bus handshake on a
// single uDMA target, with address decode, wait states and a ready timeout.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for psel; latches address/data/direction on launch
//   ST_ACCESS | one cfg_valid bit high, waiting for ready or the timeout
//   ST_RESP   | response held in r_rdata/r_err, returned on psel & penable
import udma_cfg_pkg::*;

module udma_cfg_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0]     paddr_i,
  input  logic [31:0]                   pwdata_i,
  input  logic                          pwrite_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [31:0]                   cfg_data_o,
  output logic [CFG_ADDR_WIDTH-1:0]     cfg_addr_o,
  output logic                          cfg_rwn_o,
  output logic [N_PERIPHS-1:0]          cfg_valid_o,
  input  logic [N_PERIPHS-1:0][31:0]    cfg_data_i,
  input  logic [N_PERIPHS-1:0]          cfg_ready_i
);

  localparam int ID_W  = APB_ADDR_WIDTH - PERIPH_ID_LSB;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen in the last ACCESS cycle allowed before the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                    r_state, w_state_nxt;
  logic [N_PERIPHS-1:0]      r_valid;
  logic                      r_rwn;
  logic [CFG_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_data;
  logic [31:0]               r_rdata;
  logic                      r_err;
  logic [CNT_W-1:0]          r_cnt;

  logic [ID_W-1:0]           w_id;
  logic [N_PERIPHS-1:0]      w_onehot;
  logic                      w_hit;
  logic                      w_ready;
  logic [31:0]               w_rdata_sel;
  logic                      w_apb_acc;
  logic                      w_launch, w_done, w_timeout, w_cnt_clr, w_pready;
  logic                      w_unused_paddr;

  assign w_id           = paddr_i[APB_ADDR_WIDTH-1:PERIPH_ID_LSB];
  assign w_apb_acc      = psel_i & penable_i;
  assign w_ready        = |(r_valid & cfg_ready_i);
  assign w_unused_paddr = ^paddr_i[CFG_REG_LSB-1:0];

  // Peripheral decode; an out-of-range ID yields an all-zero vector.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_PERIPHS; i++) begin
      w_onehot[i] = (32'(w_id) == i);
    end
  end

  assign w_hit = |w_onehot;

  // Read-data select driven by the active valid bit, avoiding a wide index.
  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < N_PERIPHS; i++) begin
      w_rdata_sel = w_rdata_sel | ({32{r_valid[i]}} & cfg_data_i[i]);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and control strobes; ready beats an expiring count.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_pready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (psel_i) begin
          w_launch    = 1'b1;
          w_state_nxt = w_hit ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (w_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_pready = w_apb_acc;
        // A dropped psel is an abort: leave without responding.
        if (w_apb_acc || !psel_i) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request and response registers; cfg fields hold until the next launch.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
      r_rwn   <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_addr  <= paddr_i[CFG_REG_LSB +: CFG_ADDR_WIDTH];
        r_data  <= pwdata_i;
        r_rwn   <= ~pwrite_i;
        r_valid <= w_onehot;
        if (!w_hit) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (w_done) begin
        r_rdata <= r_rwn ? w_rdata_sel : 32'h0;
        r_err   <= 1'b0;
        r_valid <= '0;
      end
      if (w_timeout) begin
        r_valid <= '0;
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  // Timeout counter: counts ACCESS cycles without ready.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (r_state == ST_ACCESS && !w_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cfg_valid_o = r_valid;
  assign cfg_rwn_o   = r_rwn;
  assign cfg_addr_o  = r_addr;
  assign cfg_data_o  = r_data;
  assign pready_o    = w_pready;
  assign prdata_o    = w_pready ? r_rdata : 32'h0;
  assign pslverr_o   = w_pready & r_err;

endmodule

// File: tb/tb_udma_cfg_master.sv
// Directed bench for udma_cfg_master: vector table plus multi-cycle sequences.
module tb_udma_cfg_master;

  logic              clk = 1'b0;
  logic              rstn;
  logic [11:0]       paddr;
  logic [31:0]       pwdata;
  logic              pwrite, psel, penable;
  logic [31:0]       prdata_o;
  logic              pready_o, pslverr_o;
  logic [31:0]       cfg_data_o;
  logic [4:0]        cfg_addr_o;
  logic              cfg_rwn_o;
  logic [5:0]        cfg_valid_o;
  logic [5:0][31:0]  cfg_data;
  logic [5:0]        cfg_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  udma_cfg_master #(.APB_ADDR_WIDTH(12), .N_PERIPHS(6), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel), .penable_i(penable),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o), .cfg_data_i(cfg_data), .cfg_ready_i(cfg_ready)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          tgt;
    logic [31:0] din;
    logic [5:0]  ready;
    logic [5:0]  e_vor;
    int          e_vcyc;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [4:0]  e_addr;
    logic        e_rwn;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One APB transfer. If rc >= 0, target rid sees ready (and data d) only in
  // cycle rc counted from the setup cycle (cycle 0). lat = cycle of pready.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          input int rid, input int rc, input logic [31:0] d,
                          output logic [31:0] rd, output logic err,
                          output logic [5:0] vor, output int vcyc, output int lat);
    int c;
    vor = '0; vcyc = 0; lat = -1; rd = '0; err = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    c = 0;
    while (lat < 0 && c <= 40) begin
      if (rc >= 0) begin
        cfg_ready[rid] = (c == rc);
        cfg_data[rid]  = (c == rc) ? d : 32'h0;
      end
      @(negedge clk);
      vor = vor | cfg_valid_o;
      if (|cfg_valid_o) vcyc++;
      if (pready_o) begin
        lat = c;
        rd  = prdata_o;
        err = pslverr_o;
      end
      @(posedge clk); #1;
      if (lat < 0) penable = 1'b1;
      else begin psel = 1'b0; penable = 1'b0; end
      c++;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [5:0]  vor;
    int          vcyc, lat;

    //          wr    addr     wdata         tgt din           ready   vor    vc  lat rdata         err  addr  rwn  data
    vecs[0] = '{1'b1, 12'h000, 32'h00000015, 0, 32'h0BADF00D, 6'h3F, 6'h01, 1,  2,  32'h00000000, 1'b0, 5'd0,  1'b0, 32'h00000015};
    vecs[1] = '{1'b0, 12'h084, 32'h00000000, 1, 32'hA5A50102, 6'h3F, 6'h02, 1,  2,  32'hA5A50102, 1'b0, 5'd1,  1'b1, 32'h00000000};
    vecs[2] = '{1'b0, 12'h17C, 32'h00000000, 2, 32'h12345678, 6'h3F, 6'h04, 1,  2,  32'h12345678, 1'b0, 5'd31, 1'b1, 32'h00000000};
    vecs[3] = '{1'b1, 12'h28C, 32'hCAFEF00D, 5, 32'h77777777, 6'h3F, 6'h20, 1,  2,  32'h00000000, 1'b0, 5'd3,  1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 12'h304, 32'h00000077, 0, 32'h11111111, 6'h3F, 6'h00, 0,  1,  32'h00000000, 1'b1, 5'd1,  1'b0, 32'h00000077};
    vecs[5] = '{1'b0, 12'hF84, 32'hDEADBEEF, 0, 32'h11111111, 6'h3F, 6'h00, 0,  1,  32'h00000000, 1'b1, 5'd1,  1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 12'h200, 32'h00000000, 4, 32'h0F0F0F0F, 6'h10, 6'h10, 1,  2,  32'h0F0F0F0F, 1'b0, 5'd0,  1'b1, 32'h00000000};
    vecs[7] = '{1'b1, 12'h18C, 32'h00C0FFEE, 3, 32'h22222222, 6'h37, 6'h08, 16, 17, 32'h00000000, 1'b1, 5'd3,  1'b0, 32'h00C0FFEE};
    vecs[8] = '{1'b0, 12'h000, 32'h00000000, 0, 32'h89ABCDEF, 6'h3F, 6'h01, 1,  2,  32'h89ABCDEF, 1'b0, 5'd0,  1'b1, 32'h00000000};

    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cfg_ready = 6'h3F;
    for (int i = 0; i < 6; i++) cfg_data[i] = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  32'(cfg_valid_o), 32'h0);
    chk("rst_rwn",    32'(cfg_rwn_o),   32'h1);
    chk("rst_addr",   32'(cfg_addr_o),  32'h0);
    chk("rst_data",   cfg_data_o,       32'h0);
    chk("rst_prdata", prdata_o,         32'h0);
    chk("rst_pready", 32'(pready_o),    32'h0);
    chk("rst_slverr", 32'(pslverr_o),   32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 6; i++) cfg_data[i] = 32'hFFFFFFFF;
      cfg_data[vecs[v].tgt] = vecs[v].din;
      cfg_ready = vecs[v].ready;
      apb_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0, -1, 32'h0, rd, err, vor, vcyc, lat);
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), 32'(vor),  32'(vecs[v].e_vor));
      chk($sformatf("v%0d_vcyc", v),  32'(vcyc), 32'(vecs[v].e_vcyc));
      chk($sformatf("v%0d_lat", v),   32'(lat),  32'(vecs[v].e_lat));
      chk($sformatf("v%0d_rdata", v), rd,        vecs[v].e_rdata);
      chk($sformatf("v%0d_err", v),   32'(err),  32'(vecs[v].e_err));
      chk($sformatf("v%0d_addr", v),  32'(cfg_addr_o), 32'(vecs[v].e_addr));
      chk($sformatf("v%0d_rwn", v),   32'(cfg_rwn_o),  32'(vecs[v].e_rwn));
      chk($sformatf("v%0d_cdata", v), cfg_data_o,      vecs[v].e_data);
      chk($sformatf("v%0d_idle_valid", v), 32'(cfg_valid_o), 32'h0);
    end

    // Late ready (3 cycles after valid), ready on the last allowed cycle,
    // and ready one cycle too late.
    cfg_ready = 6'h00;
    for (int i = 0; i < 6; i++) cfg_data[i] = 32'h0;
    apb_xfer(1'b0, 12'h108, 32'h0, 2, 4, 32'hDEAD0000, rd, err, vor, vcyc, lat);
    chk("late_vcyc",  32'(vcyc), 32'd4);
    chk("late_lat",   32'(lat),  32'd5);
    chk("late_rdata", rd,        32'hDEAD0000);
    chk("late_err",   32'(err),  32'h0);
    chk("late_valid", 32'(vor),  32'h04);
    chk("late_addr",  32'(cfg_addr_o), 32'd2);

    apb_xfer(1'b0, 12'h104, 32'h0, 2, 16, 32'h600DCAFE, rd, err, vor, vcyc, lat);
    chk("edge_vcyc",  32'(vcyc), 32'd16);
    chk("edge_lat",   32'(lat),  32'd17);
    chk("edge_rdata", rd,        32'h600DCAFE);
    chk("edge_err",   32'(err),  32'h0);

    apb_xfer(1'b0, 12'h104, 32'h0, 2, 17, 32'h5EE5EE5E, rd, err, vor, vcyc, lat);
    chk("tmo_vcyc",  32'(vcyc), 32'd16);
    chk("tmo_lat",   32'(lat),  32'd17);
    chk("tmo_rdata", rd,        32'h0);
    chk("tmo_err",   32'(err),  32'h1);

    // Master abort while the DUT holds an error response.
    cfg_ready = 6'h3F;
    cfg_data[1] = 32'h13579BDF;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h300; pwdata = 32'h0;
    @(posedge clk); #1;
    psel = 1'b0;
    @(negedge clk);
    chk("abort_pready", 32'(pready_o), 32'h0);
    chk("abort_valid",  32'(cfg_valid_o), 32'h0);
    apb_xfer(1'b0, 12'h080, 32'h0, 0, -1, 32'h0, rd, err, vor, vcyc, lat);
    chk("post_abort_lat",   32'(lat), 32'd2);
    chk("post_abort_rdata", rd,       32'h13579BDF);
    chk("post_abort_err",   32'(err), 32'h0);

    // Asynchronous reset during ACCESS with ready held low.
    cfg_ready = 6'h00;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h99;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pre_valid", 32'(cfg_valid_o), 32'h01);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid",  32'(cfg_valid_o), 32'h0);
    chk("rst_mid_pready", 32'(pready_o),    32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_hold_valid", 32'(cfg_valid_o), 32'h0);
    rstn = 1'b1;
    cfg_ready = 6'h3F;
    apb_xfer(1'b1, 12'h000, 32'h0000005A, 0, -1, 32'h0, rd, err, vor, vcyc, lat);
    chk("post_rst_lat",   32'(lat),  32'd2);
    chk("post_rst_vcyc",  32'(vcyc), 32'd1);
    chk("post_rst_err",   32'(err),  32'h0);
    chk("post_rst_cdata", cfg_data_o, 32'h0000005A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
